// File: rtl/pam_mult_pkg.sv
// rtl/pam_mult_pkg.sv - shared constants and column-keep mask for the approximate multiplier
package pam_mult_pkg;

    localparam int W_MIN = 4;
    localparam int W_MAX = 16;
    localparam int L_MIN = 0;
    localparam int L_MAX = 2 * W_MAX - 2;

    // Bit c is set when product column c survives truncation at level l.
    function automatic logic [2*W_MAX-1:0] keep_mask(input int w, input int l);
        logic [2*W_MAX-1:0] m;
        m = '0;
        for (int c = 0; c < 2 * W_MAX; c++) begin
            if (c >= l && c < 2 * w) begin
                m[c] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/approx_pp_reduce.sv
// rtl/approx_pp_reduce.sv - partial-product generation, column masking and carry-save reduction to two rows
module approx_pp_reduce
    import pam_mult_pkg::*;
#(
    parameter int W = 8,
    parameter int L = 6
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic           mode,
    output logic [2*W-1:0] sum_row,
    output logic [2*W-1:0] carry_row
);

    localparam logic [2*W_MAX-1:0] KEEP_FULL = keep_mask(W, L);
    localparam logic [2*W-1:0]     KEEP      = KEEP_FULL[2*W-1:0];

    logic [2*W-1:0] mask;
    logic [2*W-1:0] pp;
    logic [2*W-1:0] s;
    logic [2*W-1:0] c;

    // Carries out of the top column are discarded: the true product always fits in 2*W bits.
    always_comb begin
        mask = mode ? KEEP : '1;
        pp   = '0;
        s    = '0;
        c    = '0;
        for (int i = 0; i < W; i++) begin
            pp = ({{W{1'b0}}, x & {W{y[i]}}} << i) & mask;
            {s, c} = {s ^ c ^ pp, ((s & c) | (s & pp) | (c & pp)) << 1};
        end
        sum_row   = s;
        carry_row = c;
    end

endmodule

// File: rtl/approx_mult_pipe.sv
// rtl/approx_mult_pipe.sv - two-stage valid/ready pipelined exact/approximate unsigned multiplier
module approx_mult_pipe
    import pam_mult_pkg::*;
#(
    parameter int W = 8,
    parameter int L = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic           mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] z
);

    if (W < W_MIN || W > W_MAX || L < L_MIN || L > 2 * W - 2) begin : g_bad_params
        $error("approx_mult_pipe: W or L outside legal range");
    end

    logic [2*W-1:0] pp_sum;
    logic [2*W-1:0] pp_carry;
    logic           s1_valid;
    logic [2*W-1:0] s1_sum;
    logic [2*W-1:0] s1_carry;
    logic           s2_open;
    logic           s1_advance;

    // Mode is applied before S1, so each pair's rows already carry its own truncation.
    approx_pp_reduce #(
        .W(W),
        .L(L)
    ) u_reduce (
        .x        (x),
        .y        (y),
        .mode     (mode),
        .sum_row  (pp_sum),
        .carry_row(pp_carry)
    );

    assign s2_open    = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_open;
    assign in_ready   = !s1_valid || s1_advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_carry <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum   <= pp_sum;
                s1_carry <= pp_carry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            z         <= '0;
        end else if (s2_open) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                z <= s1_sum + s1_carry;
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb/tb_approx_mult_pipe.sv - self-checking bench for approx_mult_pipe
module tb_approx_mult_pipe;

    typedef struct {
        logic        m;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_b;
    logic        out_ready_b;
    logic        mode_b;
    logic [15:0] x_b;
    logic [15:0] y_b;
    int          sel;

    logic        iv0, iv1, iv2;
    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic [15:0] z0;
    logic [23:0] z1;
    logic [31:0] z2;
    logic        ir_s, ov_s;
    logic [31:0] z_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign iv0 = in_valid_b && (sel == 0);
    assign iv1 = in_valid_b && (sel == 1);
    assign iv2 = in_valid_b && (sel == 2);

    approx_mult_pipe #(.W(8), .L(6)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .x(x_b[7:0]), .y(y_b[7:0]),
        .mode(mode_b), .out_valid(ov0), .out_ready(out_ready_b), .z(z0)
    );
    approx_mult_pipe #(.W(12), .L(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .x(x_b[11:0]), .y(y_b[11:0]),
        .mode(mode_b), .out_valid(ov1), .out_ready(out_ready_b), .z(z1)
    );
    approx_mult_pipe #(.W(16), .L(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .x(x_b), .y(y_b),
        .mode(mode_b), .out_valid(ov2), .out_ready(out_ready_b), .z(z2)
    );

    always_comb begin
        ir_s = ir0;
        ov_s = ov0;
        z_s  = {16'd0, z0};
        if (sel == 1) begin
            ir_s = ir1;
            ov_s = ov1;
            z_s  = {8'd0, z1};
        end else if (sel == 2) begin
            ir_s = ir2;
            ov_s = ov2;
            z_s  = z2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Product as the sum of surviving bit products; mode 0 keeps every column.
    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                             input logic m, input int w, input int l);
        logic [31:0] acc;
        acc = 32'd0;
        for (int i = 0; i < w; i++) begin
            for (int j = 0; j < w; j++) begin
                if (a[i] && b[j] && (!m || (i + j) >= l)) begin
                    acc += 32'd1 << (i + j);
                end
            end
        end
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input vec_t v);
        mode_b = v.m;
        x_b    = v.a;
        y_b    = v.b;
    endtask

    task automatic run_single(input vec_t v, input int idx);
        in_valid_b  = 1'b1;
        out_ready_b = 1'b1;
        set_in(v);
        @(negedge clk);
        check($sformatf("vec%0d in_ready", idx), ir_s, 1'b1);
        tick();
        in_valid_b = 1'b0;
        @(negedge clk);
        check($sformatf("vec%0d early out_valid", idx), ov_s, 1'b0);
        tick();
        @(negedge clk);
        check($sformatf("vec%0d out_valid", idx), ov_s, 1'b1);
        check($sformatf("vec%0d z", idx), z_s, v.e);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[9];
        vec_t        bb[3];
        logic        ov_h[6];
        logic [31:0] z_h[6];
        logic [31:0] got[$];
        logic [31:0] exp_q[$];
        int          w_t[3];
        int          l_t[3];
        bit          accepted;

        vecs[0] = '{1'b1, 16'd255, 16'd255, 32'd64704};
        vecs[1] = '{1'b0, 16'd255, 16'd255, 32'd65025};
        vecs[2] = '{1'b1, 16'd3,   16'd3,   32'd0};
        vecs[3] = '{1'b1, 16'd128, 16'd1,   32'd128};
        vecs[4] = '{1'b0, 16'd7,   16'd9,   32'd63};
        vecs[5] = '{1'b1, 16'd7,   16'd9,   32'd0};
        vecs[6] = '{1'b1, 16'd255, 16'd1,   32'd192};
        vecs[7] = '{1'b1, 16'd64,  16'd2,   32'd128};
        vecs[8] = '{1'b0, 16'd0,   16'd0,   32'd0};
        w_t = '{8, 12, 16};
        l_t = '{6, 8, 0};

        sel         = 0;
        in_valid_b  = 1'b0;
        out_ready_b = 1'b0;
        mode_b      = 1'b0;
        x_b         = '0;
        y_b         = '0;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;
        #2;
        check("reset out_valid w8", ov0, 1'b0);
        check("reset out_valid w12", ov1, 1'b0);
        check("reset out_valid w16", ov2, 1'b0);
        check("reset in_ready w8", ir0, 1'b1);
        check("reset z w8", {16'd0, z0}, 32'd0);
        check("reset z w16", z2, 32'd0);
        tick();
        tick();
        check("in_ready held in reset", ir0, 1'b1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_single(vecs[i], i);
        end

        bb[0] = vecs[0];
        bb[1] = vecs[1];
        bb[2] = vecs[4];
        out_ready_b = 1'b1;
        for (int t = 0; t < 6; t++) begin
            in_valid_b = (t < 3);
            if (t < 3) set_in(bb[t]);
            @(negedge clk);
            ov_h[t] = ov_s;
            z_h[t]  = z_s;
            if (t < 3) check("b2b in_ready", ir_s, 1'b1);
            tick();
        end
        for (int t = 0; t < 6; t++) begin
            check($sformatf("b2b out_valid t%0d", t), ov_h[t], (t >= 2 && t <= 4));
            if (t >= 2 && t <= 4) check($sformatf("b2b z t%0d", t), z_h[t], bb[t-2].e);
        end

        bb[2] = vecs[6];
        out_ready_b = 1'b0;
        in_valid_b  = 1'b1;
        for (int t = 0; t < 2; t++) begin
            set_in(bb[t]);
            @(negedge clk);
            check("bp accept", ir_s, 1'b1);
            tick();
        end
        set_in(bb[2]);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("bp in_ready low", ir_s, 1'b0);
            check("bp out_valid held", ov_s, 1'b1);
            check("bp z stable", z_s, bb[0].e);
            tick();
        end
        out_ready_b = 1'b1;
        got.delete();
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            accepted = in_valid_b && ir_s;
            if (ov_s && out_ready_b) got.push_back(z_s);
            tick();
            if (accepted) in_valid_b = 1'b0;
        end
        check("bp in_valid cleared", in_valid_b, 1'b0);
        check("bp result count", got.size(), 3);
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            check($sformatf("bp result %0d", k), got[k], bb[k].e);
        end

        out_ready_b = 1'b0;
        in_valid_b  = 1'b1;
        set_in(bb[0]);
        tick();
        set_in(bb[1]);
        tick();
        in_valid_b = 1'b0;
        @(negedge clk);
        check("rst pre out_valid", ov_s, 1'b1);
        check("rst pre in_ready", ir_s, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("rst async out_valid", ov_s, 1'b0);
        check("rst async in_ready", ir_s, 1'b1);
        check("rst async z", z_s, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready_b = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            check("post-reset out_valid", ov_s, 1'b0);
            tick();
        end

        for (int s = 0; s < 3; s++) begin
            int          sent;
            int          cycles;
            int          m;
            bit          stalled_prev;
            logic [31:0] prev_z;
            sel          = s;
            m            = (1 << w_t[s]) - 1;
            sent         = 0;
            cycles       = 0;
            stalled_prev = 1'b0;
            prev_z       = '0;
            exp_q.delete();
            in_valid_b   = 1'b0;
            while ((sent < 10000 || exp_q.size() != 0) && cycles < 40000) begin
                if (!in_valid_b && sent < 10000 && $urandom_range(0, 7) != 0) begin
                    in_valid_b = 1'b1;
                    x_b        = 16'($urandom & m);
                    y_b        = 16'($urandom & m);
                    mode_b     = 1'($urandom_range(0, 1));
                end
                out_ready_b = ($urandom_range(0, 4) != 0);
                @(negedge clk);
                if (stalled_prev) begin
                    check("rand hold out_valid", ov_s, 1'b1);
                    check("rand hold z", z_s, prev_z);
                end
                stalled_prev = ov_s && !out_ready_b;
                prev_z       = z_s;
                if (ov_s && out_ready_b) begin
                    if (exp_q.size() == 0) check("rand spurious output", ov_s, 1'b0);
                    else check($sformatf("rand z w%0d", w_t[s]), z_s, exp_q.pop_front());
                end
                accepted = in_valid_b && ir_s;
                if (accepted) begin
                    if (l_t[s] == 0) exp_q.push_back({16'd0, x_b} * {16'd0, y_b});
                    else exp_q.push_back(ref_prod(x_b, y_b, mode_b, w_t[s], l_t[s]));
                    sent++;
                end
                tick();
                cycles++;
                if (accepted) in_valid_b = 1'b0;
            end
            check($sformatf("rand leftover w%0d", w_t[s]), exp_q.size() + (10000 - sent), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/approx_mult_pipe.md
APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

Interface
REQ-001 SHALL have parameter W, default 8: operand width in bits, legal range 4..16.
REQ-002 SHALL have parameter L, default 6: approximation level, i.e. number of low product columns truncated in approximate mode; legal range 0..2*W-2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the offered pair this cycle.
REQ-007 SHALL have port x, input, W bits: unsigned multiplicand.
REQ-008 SHALL have port y, input, W bits: unsigned multiplier.
REQ-009 SHALL have port mode, input, 1 bit: 0 = exact product, 1 = approximate product; sampled together with x and y.
REQ-010 SHALL have port out_valid, output, 1 bit: z holds a result.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port z, output, 2*W bits: product.

Function
REQ-013 SHALL transfer input when in_valid and in_ready are both 1 in the same cycle, and output when out_valid and out_ready are both 1.
REQ-014 SHALL compute, for mode=0, z = x*y exactly, modulo nothing (2*W bits are always sufficient).
REQ-015 SHALL compute, for mode=1, z = sum of x[i]&y[j] * 2^(i+j) over all i,j with i+j >= L; partial products in columns below L are dropped, with no compensation constant.
REQ-016 SHALL be a two-stage pipeline: S1 registers generated and reduced partial-product rows plus mode; S2 registers the final carry-propagate sum into z.
REQ-017 SHALL have a latency of exactly 2 cycles from input transfer to out_valid=1 when out_ready is held 1.
REQ-018 SHALL sustain one transfer per cycle when out_ready is held 1.
REQ-019 SHALL advance each stage only if that stage is empty or the stage downstream advances in the same cycle.
REQ-020 SHALL drive in_ready = !S1_valid || S1_advance; in_ready SHALL NOT depend on in_valid.
REQ-021 SHALL hold z and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL keep the mode of each operand pair attached to that pair; a mode change between back-to-back pairs SHALL NOT affect pairs already accepted.
REQ-023 SHALL, with pipeline full and out_ready=0, hold in_ready=0 and drop nothing; a simultaneous output and input transfer SHALL keep both stages occupied.
REQ-024 SHALL make z don't-care while out_valid=0; it SHALL still be deterministic (registered).

Reset
REQ-025 SHALL clear S1_valid, S2_valid and out_valid to 0 and z to 0 immediately on rst_n low, with no clock required.
REQ-026 SHALL drive in_ready=1 during and after reset, since all stages are empty.
REQ-027 SHALL discard all in-flight results on reset mid-operation; no result SHALL emerge after reset release unless a new input transfer occurs.

Structure
REQ-028 SHALL place in shared package pam_mult_pkg: the legal-range constants for W and L, and a function returning the column-keep mask for a given W and L.
REQ-029 SHALL use one combinational sub-module, approx_pp_reduce: partial-product generation, masking by mode/L, and reduction to two rows; it SHALL be instantiated inside S1.

Verification
REQ-030 SHALL test W=8, L=6, mode=1, x=255, y=255 -> z=64704 after 2 cycles; mode=0 with the same operands -> z=65025.
REQ-031 SHALL test mode=1, x=3, y=3 -> z=0; mode=1, x=128, y=1 -> z=128.
REQ-032 SHALL test back-to-back input of pairs (255,255,m=1), (255,255,m=0), (7,9,m=0) with out_ready=1 -> results 64704, 65025, 63 on three consecutive cycles.
REQ-033 SHALL test backpressure: fill the pipeline with out_ready=0 -> in_ready=0 after two accepts, z stable; release out_ready -> results in order, none lost or duplicated.
REQ-034 SHALL test reset asserted with two pairs in flight -> out_valid=0 at once, in_ready=1, no output after release.
REQ-035 SHALL run a random comparison of 10k pairs (mixed mode, random stalls) against a REQ-015 reference model for W=8/L=6, W=12/L=8 and W=16/L=0; L=0 SHALL equal the exact product.
